// File: rtl/dll_lock_ctrl.sv
// rtl/dll_lock_ctrl.sv - FMDLL lock sequencer: SAR acquisition, +/-1 tracking, lock/unlock detection
// Outputs are registered from next-state decode; only dly_code is a combinational mux on sel.
module dll_lock_ctrl #(
  parameter int WIDTH      = 10,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic             clk4,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             comp_in,
  input  logic [WIDTH-1:0] sar_q,
  output logic             sar_rst,
  output logic             sar_step,
  output logic [WIDTH-1:0] dly_code,
  output logic             busy,
  output logic             locked,
  output logic             lock_lost,
  output logic             sat
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0] BITS_INIT = BW'(WIDTH);
  localparam logic [RW-1:0] REV_MAX   = RW'(LOCK_CNT);
  localparam logic [UW-1:0] SAME_MAX  = UW'(UNLOCK_CNT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAR_RUN = 3'd1,
    CAPTURE = 3'd2,
    TRACK   = 3'd3,
    LOCKED  = 3'd4,
    RELOCK  = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [SW-1:0]    settle, settle_n;
  logic [BW-1:0]    bits, bits_n;
  logic [WIDTH-1:0] trk_code, trk_n;
  logic [RW-1:0]    rev_cnt, rev_n;
  logic [UW-1:0]    same_cnt, same_n;
  logic             dir_vld, vld_n;
  logic             last_dir, dir_n;
  logic             sel;
  logic             step_n, lost_n, sat_n;

  logic             action;
  logic             blocked;
  logic             reversal;
  logic [RW-1:0]    rev_inc;
  logic [UW-1:0]    same_inc;

  assign action   = (settle == '0);
  assign blocked  = comp_in ? (&trk_code) : (trk_code == '0);
  assign reversal = dir_vld && (comp_in != last_dir);
  assign rev_inc  = (rev_cnt == REV_MAX) ? rev_cnt : rev_cnt + RW'(1);
  assign same_inc = (same_cnt == SAME_MAX) ? same_cnt : same_cnt + UW'(1);

  always_comb begin
    state_n  = state;
    settle_n = settle;
    bits_n   = bits;
    trk_n    = trk_code;
    rev_n    = rev_cnt;
    same_n   = same_cnt;
    vld_n    = dir_vld;
    dir_n    = last_dir;
    step_n   = 1'b0;
    lost_n   = 1'b0;
    sat_n    = 1'b0;

    // Settle window free-runs in every active state so steps stay evenly spaced.
    if (state != IDLE) begin
      settle_n = action ? SETTLE_M1 : settle - SW'(1);
    end

    case (state)
      IDLE: begin
        settle_n = '0;
        if (start) begin
          state_n  = SAR_RUN;
          settle_n = SETTLE_M1;
          bits_n   = BITS_INIT;
        end
      end
      SAR_RUN: begin
        if (action) begin
          step_n = 1'b1;
          bits_n = bits - BW'(1);
          if (bits == BW'(1)) state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        trk_n   = sar_q;
        rev_n   = '0;
        same_n  = '0;
        vld_n   = 1'b0;
        state_n = TRACK;
      end
      TRACK, LOCKED: begin
        if (action) begin
          // A blocked step still records its direction for lock detection.
          if (blocked) sat_n = 1'b1;
          else         trk_n = comp_in ? trk_code + WIDTH'(1) : trk_code - WIDTH'(1);
          dir_n = comp_in;
          vld_n = 1'b1;
          if (reversal) begin
            rev_n  = rev_inc;
            same_n = UW'(1);
          end else begin
            rev_n  = '0;
            same_n = same_inc;
          end
          if (state == TRACK && rev_n == REV_MAX) state_n = LOCKED;
          if (state == LOCKED && same_n == SAME_MAX) begin
            state_n = RELOCK;
            lost_n  = 1'b1;
          end
        end
      end
      RELOCK: begin
        state_n  = SAR_RUN;
        settle_n = SETTLE_M1;
        bits_n   = BITS_INIT;
      end
      default: state_n = IDLE;
    endcase

    if (!en) begin
      state_n  = IDLE;
      settle_n = '0;
      step_n   = 1'b0;
      lost_n   = 1'b0;
      sat_n    = 1'b0;
    end
  end

  always_ff @(posedge clk4) begin
    if (!rst_n) begin
      state     <= IDLE;
      settle    <= '0;
      bits      <= '0;
      trk_code  <= '0;
      rev_cnt   <= '0;
      same_cnt  <= '0;
      dir_vld   <= 1'b0;
      last_dir  <= 1'b0;
      sel       <= 1'b0;
      sar_rst   <= 1'b1;
      sar_step  <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_n;
      settle    <= settle_n;
      bits      <= bits_n;
      trk_code  <= trk_n;
      rev_cnt   <= rev_n;
      same_cnt  <= same_n;
      dir_vld   <= vld_n;
      last_dir  <= dir_n;
      sel       <= (state_n == TRACK) || (state_n == LOCKED);
      sar_rst   <= (state_n == IDLE) || (state_n == RELOCK);
      sar_step  <= step_n;
      busy      <= (state_n == SAR_RUN) || (state_n == CAPTURE) || (state_n == RELOCK);
      locked    <= (state_n == LOCKED);
      lock_lost <= lost_n;
      sat       <= sat_n;
    end
  end

  assign dly_code = sel ? trk_code : sar_q;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb/tb_dll_lock_ctrl.sv - directed bench for dll_lock_ctrl with SAR/PD models and strobe scoreboard
module tb_dll_lock_ctrl;

  logic       clk4 = 1'b0;
  logic       rst_n, en, start;
  logic       comp_in, sar_rst, sar_step, busy, locked, lock_lost, sat;
  logic [9:0] sar_q = 10'h200;
  logic [9:0] dly_code;
  logic       en1, start1;
  logic       comp_in1, sar_rst1, sar_step1, busy1, locked1, lock_lost1, sat1;
  logic [9:0] sar_q1 = 10'h200;
  logic [9:0] dly_code1;

  logic [9:0] ideal = 10'd613;
  logic       force_on = 1'b0;
  logic       force_val = 1'b0;
  int         sbit = 9;
  int         sbit1 = 9;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         exp_q[$];

  always #5 clk4 = ~clk4;
  always @(posedge clk4) cyc <= cyc + 1;

  dll_lock_ctrl dut (
    .clk4(clk4), .rst_n(rst_n), .en(en), .start(start), .comp_in(comp_in),
    .sar_q(sar_q), .sar_rst(sar_rst), .sar_step(sar_step), .dly_code(dly_code),
    .busy(busy), .locked(locked), .lock_lost(lock_lost), .sat(sat)
  );

  dll_lock_ctrl #(.SETTLE_CYC(1)) dut1 (
    .clk4(clk4), .rst_n(rst_n), .en(en1), .start(start1), .comp_in(comp_in1),
    .sar_q(sar_q1), .sar_rst(sar_rst1), .sar_step(sar_step1), .dly_code(dly_code1),
    .busy(busy1), .locked(locked1), .lock_lost(lock_lost1), .sat(sat1)
  );

  // Phase detector: lead while the code is at or below the ideal point.
  assign comp_in  = force_on ? force_val : (dly_code <= ideal);
  assign comp_in1 = (dly_code1 <= 10'd613);

  always @(posedge clk4) begin
    if (sar_rst === 1'b1) begin
      sar_q <= 10'h200;
      sbit  <= 9;
    end else if (sar_step === 1'b1 && sbit >= 0) begin
      if (!comp_in) sar_q[sbit] <= 1'b0;
      if (sbit > 0) sar_q[sbit-1] <= 1'b1;
      sbit <= sbit - 1;
    end
  end

  always @(posedge clk4) begin
    if (sar_rst1 === 1'b1) begin
      sar_q1 <= 10'h200;
      sbit1  <= 9;
    end else if (sar_step1 === 1'b1 && sbit1 >= 0) begin
      if (!comp_in1) sar_q1[sbit1] <= 1'b0;
      if (sbit1 > 0) sar_q1[sbit1-1] <= 1'b1;
      sbit1 <= sbit1 - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe scoreboard: each sar_step must land on the next expected absolute cycle.
  always @(negedge clk4) begin
    if (sar_step === 1'b1) begin
      if (exp_q.size() == 0) check("strobe_extra_qsize", exp_q.size(), 1);
      else check("strobe_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk4);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push_search(input int s);
    for (int k = 1; k <= 10; k++) exp_q.push_back(s + 4 * k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int waited;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; en1 = 1'b0; start1 = 1'b0;
    tick(); tick();
    check("rst_sar_rst", sar_rst, 1);
    check("rst_sar_step", sar_step, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_sat", sat, 0);
    check("rst_dly_code", dly_code, sar_q);
    rst_n = 1'b1; en = 1'b1;
    tick();

    // Search and lock
    s = cyc + 1;
    push_search(s);
    start = 1'b1; tick(); start = 1'b0;
    check("run_busy", busy, 1);
    check("run_sar_rst", sar_rst, 0);
    wait_to(s + 10);
    start = 1'b1; tick(); start = 1'b0;
    wait_to(s + 40);
    check("pre_capture_busy", busy, 1);
    wait_to(s + 41);
    check("capture_code", dly_code, 613);
    check("track_busy", busy, 0);
    check("track_locked", locked, 0);
    check("search_queue_empty", exp_q.size(), 0);
    while (cyc < s + 75) begin
      tick();
      check("dither_range", (dly_code >= 10'd612 && dly_code <= 10'd614), 1);
    end
    check("pre_lock", locked, 0);
    tick();
    check("lock_at_8th_rev", locked, 1);
    check("lock_code", dly_code, 614);
    wait_to(s + 80);
    check("lock_hold_code", dly_code, 613);

    // Loss of lock
    force_on = 1'b1; force_val = 1'b1;
    push_search(s + 97);
    wait_to(s + 84); check("unlock_step1", dly_code, 614);
    wait_to(s + 88); check("unlock_step2", dly_code, 615);
    wait_to(s + 92); check("unlock_step3", dly_code, 616);
    check("still_locked", locked, 1);
    wait_to(s + 96);
    check("lost_pulse", lock_lost, 1);
    check("lost_locked", locked, 0);
    check("relock_sar_rst", sar_rst, 1);
    check("relock_busy", busy, 1);
    force_on = 1'b0;
    tick();
    check("lost_pulse_end", lock_lost, 0);
    check("relock_sar_rst_end", sar_rst, 0);
    check("relock_run_busy", busy, 1);
    wait_to(s + 97 + 41);
    check("relock_capture", dly_code, 613);
    check("relock_queue_empty", exp_q.size(), 0);
    waited = 0;
    while (locked !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    check("relock_locked", locked, 1);

    // Reset while locked, start during reset ignored
    rst_n = 1'b0; start = 1'b1;
    tick();
    check("rst2_sar_rst", sar_rst, 1);
    check("rst2_locked", locked, 0);
    check("rst2_busy", busy, 0);
    check("rst2_sar_step", sar_step, 0);
    check("rst2_dly_code", dly_code, sar_q);
    rst_n = 1'b1; start = 1'b0;
    tick();
    check("rst2_idle_busy", busy, 0);

    // Abort at strobe 5
    s = cyc + 1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(s + 4 * k);
    start = 1'b1; tick(); start = 1'b0;
    wait_to(s + 20);
    check("abort_strobe5", sar_step, 1);
    en = 1'b0;
    tick();
    check("abort_sar_rst", sar_rst, 1);
    check("abort_busy", busy, 0);
    wait_to(s + 60);
    check("abort_queue_empty", exp_q.size(), 0);
    en = 1'b1;
    s = cyc + 1;
    push_search(s);
    start = 1'b1; tick(); start = 1'b0;
    wait_to(s + 41);
    check("restart_capture", dly_code, 613);
    check("restart_queue_empty", exp_q.size(), 0);

    // Saturation at the top code
    en = 1'b0; tick(); en = 1'b1;
    ideal = 10'd1023;
    s = cyc + 1;
    push_search(s);
    start = 1'b1; tick(); start = 1'b0;
    wait_to(s + 41);
    check("sat_capture", dly_code, 1023);
    for (int n = 0; n < 6; n++) begin
      wait_to(s + 44 + 4 * n);
      check("sat_pulse", sat, 1);
      check("sat_hold", dly_code, 1023);
      check("sat_no_lock", locked, 0);
      tick();
      check("sat_pulse_end", sat, 0);
    end
    en = 1'b0; tick();

    // Single-cycle settle
    en1 = 1'b1; start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("fast_strobe", sar_step1, 1);
    end
    tick();
    check("fast_strobe_end", sar_step1, 0);
    check("fast_capture", dly_code1, 613);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
